// File: rtl/tick_scheduler.sv
// tick_scheduler: free-running prescaler producing a base tick, plus NCH
// channels that turn that base tick into periodic or one-shot enable pulses.
// Channels are controlled through a valid/ready command port; each accepted
// command is held for one apply cycle before the port accepts the next one.
`timescale 1ns/1ps

module tick_scheduler #(
   parameter int BASE_DIV = 50000,
   parameter int NCH      = 4,
   parameter int PW       = 16,
   parameter int CW       = 3
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          cfg_valid,
   output logic          cfg_ready,
   input  logic [CW-1:0] cfg_ch,
   input  logic [1:0]    cfg_op,
   input  logic [PW-1:0] cfg_period,
   output logic          base_tick,
   output logic [NCH-1:0] tick,
   output logic [NCH-1:0] busy,
   output logic [NCH-1:0] done,
   output logic          cfg_err
);

   localparam int DW = (BASE_DIV > 1) ? $clog2(BASE_DIV) : 1;

   localparam logic [1:0] OP_STOP    = 2'b00;
   localparam logic [1:0] OP_START_P = 2'b01;
   localparam logic [1:0] OP_START_1 = 2'b10;
   localparam logic [1:0] OP_SET     = 2'b11;

   typedef enum logic {C_IDLE, C_APPLY} cmd_state_t;
   typedef enum logic [1:0] {CH_IDLE, CH_RUN_P, CH_RUN_1} ch_state_t;

   // ---------------- prescaler ----------------
   logic [DW-1:0] presc_q, presc_d;
   logic          base_evt;
   logic          base_tick_q, base_tick_d;

   // Wrap event is decoded from the counter; the registered copy is the
   // base_tick output, so channel pulses line up with base_tick.
   always_comb begin
      base_evt    = (presc_q == DW'(BASE_DIV - 1));
      presc_d     = base_evt ? '0 : presc_q + DW'(1);
      base_tick_d = base_evt;
   end

   // ---------------- command port ----------------
   cmd_state_t    state_q, state_d;
   logic [CW-1:0] cmd_ch_q, cmd_ch_d;
   logic [1:0]    cmd_op_q, cmd_op_d;
   logic [PW-1:0] cmd_period_q, cmd_period_d;
   logic          cfg_ready_q, cfg_ready_d;

   // Command FSM: latch in C_IDLE, execute for exactly one cycle in C_APPLY.
   always_comb begin
      state_d      = state_q;
      cmd_ch_d     = cmd_ch_q;
      cmd_op_d     = cmd_op_q;
      cmd_period_d = cmd_period_q;
      case (state_q)
         C_IDLE: begin
            if (cfg_valid) begin
               cmd_ch_d     = cfg_ch;
               cmd_op_d     = cfg_op;
               cmd_period_d = cfg_period;
               state_d      = C_APPLY;
            end
         end
         C_APPLY: state_d = C_IDLE;
         default: state_d = C_IDLE;
      endcase
      cfg_ready_d = (state_d == C_IDLE);
   end

   // ---------------- channels ----------------
   ch_state_t     ch_state_q [NCH];
   ch_state_t     ch_state_d [NCH];
   logic [PW-1:0] cnt_q      [NCH];
   logic [PW-1:0] cnt_d      [NCH];
   logic [PW-1:0] per_q      [NCH];
   logic [PW-1:0] per_d      [NCH];
   logic [NCH-1:0] tick_q, tick_d;
   logic [NCH-1:0] done_q, done_d;
   logic [NCH-1:0] busy_q, busy_d;
   logic           cfg_err_q, cfg_err_d;

   logic          apply;
   logic          ch_in_range;
   logic          is_start;
   logic [PW-1:0] sel_period;
   logic          cmd_ok;

   // Validate the latched command against the target channel's stored period.
   always_comb begin
      apply       = (state_q == C_APPLY);
      ch_in_range = (int'(cmd_ch_q) < NCH);
      is_start    = (cmd_op_q == OP_START_P) || (cmd_op_q == OP_START_1);
      sel_period  = '0;
      for (int i = 0; i < NCH; i++) begin
         if (cmd_ch_q == CW'(i)) sel_period = per_q[i];
      end
      cfg_err_d = apply && (!ch_in_range || (is_start && (sel_period == '0)));
      cmd_ok    = apply && !cfg_err_d;
   end

   // Per-channel next state: an applied command wins over a coincident base
   // tick for its own channel; all other channels count normally.
   always_comb begin
      tick_d = '0;
      done_d = '0;
      busy_d = '0;
      for (int i = 0; i < NCH; i++) begin
         ch_state_d[i] = ch_state_q[i];
         cnt_d[i]      = cnt_q[i];
         per_d[i]      = per_q[i];
         if (cmd_ok && (cmd_ch_q == CW'(i))) begin
            case (cmd_op_q)
               OP_STOP:    ch_state_d[i] = CH_IDLE;
               OP_START_P: begin
                  cnt_d[i]      = per_q[i] - PW'(1);
                  ch_state_d[i] = CH_RUN_P;
               end
               OP_START_1: begin
                  cnt_d[i]      = per_q[i] - PW'(1);
                  ch_state_d[i] = CH_RUN_1;
               end
               OP_SET:     per_d[i] = cmd_period_q;
               default:    ch_state_d[i] = ch_state_q[i];
            endcase
         end else if (base_evt && (ch_state_q[i] != CH_IDLE)) begin
            if (cnt_q[i] != '0) begin
               cnt_d[i] = cnt_q[i] - PW'(1);
            end else begin
               tick_d[i] = 1'b1;
               if (ch_state_q[i] == CH_RUN_P) begin
                  // Reload from the currently stored period so a SET_PERIOD
                  // issued mid-interval takes effect from the next interval.
                  cnt_d[i] = per_q[i] - PW'(1);
               end else begin
                  done_d[i]     = 1'b1;
                  ch_state_d[i] = CH_IDLE;
               end
            end
         end
         busy_d[i] = (ch_state_d[i] != CH_IDLE);
      end
   end

   // All state and output registers; reset aborts every channel silently.
   always_ff @(posedge clk) begin
      if (reset) begin
         presc_q      <= '0;
         base_tick_q  <= 1'b0;
         state_q      <= C_IDLE;
         cmd_ch_q     <= '0;
         cmd_op_q     <= '0;
         cmd_period_q <= '0;
         cfg_ready_q  <= 1'b1;
         cfg_err_q    <= 1'b0;
         tick_q       <= '0;
         done_q       <= '0;
         busy_q       <= '0;
         for (int i = 0; i < NCH; i++) begin
            ch_state_q[i] <= CH_IDLE;
            cnt_q[i]      <= '0;
            per_q[i]      <= '0;
         end
      end else begin
         presc_q      <= presc_d;
         base_tick_q  <= base_tick_d;
         state_q      <= state_d;
         cmd_ch_q     <= cmd_ch_d;
         cmd_op_q     <= cmd_op_d;
         cmd_period_q <= cmd_period_d;
         cfg_ready_q  <= cfg_ready_d;
         cfg_err_q    <= cfg_err_d;
         tick_q       <= tick_d;
         done_q       <= done_d;
         busy_q       <= busy_d;
         for (int i = 0; i < NCH; i++) begin
            ch_state_q[i] <= ch_state_d[i];
            cnt_q[i]      <= cnt_d[i];
            per_q[i]      <= per_d[i];
         end
      end
   end

   assign base_tick = base_tick_q;
   assign cfg_ready = cfg_ready_q;
   assign cfg_err   = cfg_err_q;
   assign tick      = tick_q;
   assign done      = done_q;
   assign busy      = busy_q;

endmodule
